lsu_axi_gen2: RTL and testbench

Parametrised load/store unit between the EX and WB stages of the ysyx_24100029 pipeline. It accepts one instruction bundle per valid/ready handshake and issues at most one single-beat AXI4 read or write with size-correct strobes and lanes. It returns the extended load data, or the store completion, plus an access-fault code downstream. Non-memory bundles pass through with one cycle of latency.

---
 rtl/lsu_axi_gen2.sv | 237 +++++++++++++++++++++++
 tb/tb_lsu_axi_gen2.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_gen2.sv
// Load/store unit between EX and WB: one single-beat AXI4 read or write per accepted bundle.
// Build option: define LSU_MISALIGN_CHECK_EN to fault misaligned accesses instead of issuing them.
module lsu_axi_gen2 #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4,
   parameter int AXI_ID = 0,
   parameter int SB_W   = 72
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_mem_ren,
   input  logic                in_mem_wen,
   input  logic [2:0]          in_funct3,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DATA_W-1:0]   in_wdata,
   input  logic [SB_W-1:0]     in_sb,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_rdata,
   output logic [1:0]          out_fault,
   output logic [SB_W-1:0]     out_sb,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [ID_W-1:0]     awid,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   input  logic [ID_W-1:0]     bid,
   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   output logic [ID_W-1:0]     arid,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic [ID_W-1:0]     rid,
   output logic                busy
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [SB_W-1:0]     sb_q, sb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          fault_q, fault_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic                accept, mem_op, mem_legal, mem_aligned;
   logic [OFF_W-1:0]    off;
   logic [3:0]          nbytes;
   logic [15:0]         strb_full;
   logic                unused_ok;

   function automatic logic load_ok(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_ok = 1'b1;
         3'b011, 3'b110:                         load_ok = (DATA_W == 64);
         default:                                load_ok = 1'b0;
      endcase
   endfunction

   function automatic logic store_ok(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: store_ok = 1'b1;
         3'b011:                 store_ok = (DATA_W == 64);
         default:                store_ok = 1'b0;
      endcase
   endfunction

   function automatic logic is_aligned(input logic [2:0] a, input logic [1:0] sz);
      case (sz)
         2'b00:   is_aligned = 1'b1;
         2'b01:   is_aligned = ~a[0];
         2'b10:   is_aligned = (a[1:0] == 2'b00);
         default: is_aligned = (a[2:0] == 3'b000);
      endcase
   endfunction

   // Sign/zero extension of the lane-aligned load data; funct3[2] selects zero extension.
   function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] d, input logic [2:0] f3);
      int   keep;
      logic fill;
      case (f3[1:0])
         2'b00:   begin keep = 8;      fill = d[7];  end
         2'b01:   begin keep = 16;     fill = d[15]; end
         2'b10:   begin keep = 32;     fill = d[31]; end
         default: begin keep = DATA_W; fill = 1'b0;  end
      endcase
      fill = fill & ~f3[2];
      for (int i = 0; i < DATA_W; i++)
         load_ext[i] = (i < keep) ? d[i] : fill;
   endfunction

   assign off       = addr_q[OFF_W-1:0];
   assign nbytes    = 4'd1 << funct3_q[1:0];
   assign strb_full = ((16'd1 << nbytes) - 16'd1) << off;

   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_rdata = rdata_q;
   assign out_fault = fault_q;
   assign out_sb    = sb_q;

   assign arvalid = (state_q == RADDR);
   assign araddr  = addr_q;
   assign arid    = ID_W'(AXI_ID);
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, funct3_q[1:0]};
   assign arburst = 2'b01;
   assign rready  = (state_q == RDATA);

   assign awvalid = (state_q == WREQ) & ~aw_done_q;
   assign awaddr  = addr_q;
   assign awid    = ID_W'(AXI_ID);
   assign awlen   = 8'd0;
   assign awsize  = {1'b0, funct3_q[1:0]};
   assign awburst = 2'b01;
   assign wvalid  = (state_q == WREQ) & ~w_done_q;
   assign wdata   = wdata_q << {off, 3'b000};
   assign wstrb   = strb_full[STRB_W-1:0];
   assign wlast   = 1'b1;
   assign bready  = (state_q == WRESP);

   assign unused_ok = ^{bid, rid, rlast, strb_full};

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      funct3_d  = funct3_q;
      sb_d      = sb_q;
      rdata_d   = rdata_q;
      fault_d   = fault_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      mem_op    = in_mem_ren | in_mem_wen;
      mem_legal = in_mem_ren ? load_ok(in_funct3) : store_ok(in_funct3);
`ifdef LSU_MISALIGN_CHECK_EN
      mem_aligned = is_aligned(in_addr[2:0], in_funct3[1:0]);
`else
      mem_aligned = 1'b1;
`endif
      case (state_q)
         RADDR: if (arready) state_d = RDATA;
         RDATA: begin
            if (rvalid) begin
               rdata_d = (rresp != 2'b00) ? '0 : load_ext(rdata >> {off, 3'b000}, funct3_q);
               fault_d = (rresp != 2'b00) ? 2'b01 : 2'b00;
               state_d = DONE;
            end
         end
         WREQ: begin
            // AW and W complete independently; either order or together
            aw_done_d = aw_done_q | awready;
            w_done_d  = w_done_q | wready;
            if (aw_done_d & w_done_d) state_d = WRESP;
         end
         WRESP: begin
            if (bvalid) begin
               if (bresp != 2'b00) fault_d = 2'b10;
               state_d = DONE;
            end
         end
         DONE:    if (out_ready) state_d = IDLE;
         default: ;
      endcase
      if (accept) begin
         addr_d    = in_addr;
         wdata_d   = in_wdata;
         funct3_d  = in_funct3;
         sb_d      = in_sb;
         rdata_d   = '0;
         fault_d   = 2'b00;
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
         if (mem_op & ~(mem_legal & mem_aligned)) begin
            fault_d = 2'b11;
            state_d = DONE;
         end else if (in_mem_ren) begin
            state_d = RADDR;
         end else if (in_mem_wen) begin
            state_d = WREQ;
         end else begin
            state_d = DONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         sb_q      <= '0;
         rdata_q   <= '0;
         fault_q   <= 2'b00;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sb_q      <= sb_d;
         rdata_q   <= rdata_d;
         fault_q   <= fault_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Request payload registers carry no reset; they are only observed behind a valid.
   always_ff @(posedge clock) begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
   end
endmodule

// File: tb/tb_lsu_axi_gen2.sv
// Randomized bench for lsu_axi_gen2 (DATA_W=32) with a reactive AXI slave and a transaction-level model.
module tb_lsu_axi_gen2;
   localparam int AW = 32, DW = 32, IDW = 4, SBW = 72, AXI_ID = 5;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic            reset = 1'b1;
   logic            in_valid = 1'b0, in_ready;
   logic            in_mem_ren = 1'b0, in_mem_wen = 1'b0;
   logic [2:0]      in_funct3 = '0;
   logic [AW-1:0]   in_addr = '0;
   logic [DW-1:0]   in_wdata = '0;
   logic [SBW-1:0]  in_sb = '0;
   logic            out_valid, out_ready = 1'b0;
   logic [DW-1:0]   out_rdata;
   logic [1:0]      out_fault;
   logic [SBW-1:0]  out_sb;
   logic            awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast;
   logic [AW-1:0]   awaddr, araddr;
   logic [IDW-1:0]  awid, arid;
   logic [7:0]      awlen, arlen;
   logic [2:0]      awsize, arsize;
   logic [1:0]      awburst, arburst;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            bvalid = 1'b0, bready;
   logic [1:0]      bresp = '0, rresp = '0;
   logic            arvalid, arready = 1'b0, rvalid = 1'b0, rready, busy;
   logic [DW-1:0]   rdata = '0;

   lsu_axi_gen2 #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IDW), .AXI_ID(AXI_ID), .SB_W(SBW)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_sb(in_sb),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_fault(out_fault), .out_sb(out_sb),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(4'd5),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(1'b1), .rid(4'd5),
      .busy(busy)
   );

   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave configuration and observation log
   bit            sl_fast = 1'b1, sl_stall = 1'b0;
   int            sl_w_lag = 0;
   logic [DW-1:0] sl_rdata = '0;
   logic [1:0]    sl_rresp = '0, sl_bresp = '0;
   int            ar_cnt, aw_cnt, w_cnt;
   logic [AW-1:0] ar_addr, aw_addr;
   logic [2:0]    ar_size, aw_size;
   logic [17:0]   ar_misc, aw_misc;
   logic [DW-1:0] w_data;
   logic [3:0]    w_strb;
   logic          w_last;

   initial begin
      bit p_ar = 0, p_aw = 0, p_w = 0, p_r = 0, p_b = 0;
      bit rd_pend = 0, aw_got = 0, w_got = 0;
      bit ar_wait = 0, aw_wait = 0, w_wait = 0;
      int rd_dly = 0, wv_age = 0;
      logic [AW+2:0]   ar_hold = '0, aw_hold = '0;
      logic [DW+3:0]   w_hold = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
            p_ar = 0; p_aw = 0; p_w = 0; p_r = 0; p_b = 0;
            rd_pend = 0; aw_got = 0; w_got = 0; ar_wait = 0; aw_wait = 0; w_wait = 0; wv_age = 0;
         end else begin
            if (ar_wait) check("ar_hold", {arvalid, araddr, arsize}, {1'b1, ar_hold});
            if (aw_wait) check("aw_hold", {awvalid, awaddr, awsize}, {1'b1, aw_hold});
            if (w_wait)  check("w_hold", {wvalid, wdata, wstrb}, {1'b1, w_hold});
            if (p_ar) begin rd_pend = 1; rd_dly = sl_fast ? 0 : int'($urandom_range(0, 2)); end
            if (p_r) rvalid = 0;
            if (p_aw) aw_got = 1;
            if (p_w) w_got = 1;
            if (p_b) bvalid = 0;
            if (rd_pend && !rvalid) begin
               if (rd_dly == 0) begin
                  rvalid = 1; rdata = sl_rdata; rresp = sl_rresp; rd_pend = 0;
               end else rd_dly--;
            end
            if (aw_got && w_got && !bvalid) begin
               bvalid = 1; bresp = sl_bresp; aw_got = 0; w_got = 0;
            end
            wv_age  = wvalid ? wv_age + 1 : 0;
            arready = sl_stall ? 1'b0 : sl_fast ? 1'b1 : 1'($urandom_range(0, 1));
            awready = sl_stall ? 1'b0 : sl_fast ? 1'b1 : 1'($urandom_range(0, 1));
            wready  = sl_stall ? 1'b0 : ((sl_fast ? 1'b1 : 1'($urandom_range(0, 1))) && (wv_age > sl_w_lag));
            p_ar = arvalid && arready;
            p_aw = awvalid && awready;
            p_w  = wvalid && wready;
            p_r  = rvalid && rready;
            p_b  = bvalid && bready;
            if (p_ar) begin ar_cnt++; ar_addr = araddr; ar_size = arsize; ar_misc = {arlen, arburst, arid, 4'd0}; end
            if (p_aw) begin aw_cnt++; aw_addr = awaddr; aw_size = awsize; aw_misc = {awlen, awburst, awid, 4'd0}; end
            if (p_w)  begin w_cnt++; w_data = wdata; w_strb = wstrb; w_last = wlast; end
            ar_wait = arvalid && !arready; ar_hold = {araddr, arsize};
            aw_wait = awvalid && !awready; aw_hold = {awaddr, awsize};
            w_wait  = wvalid && !wready;   w_hold  = {wdata, wstrb};
         end
      end
   end

   logic [DW-1:0] res_rdata;
   logic [1:0]    res_fault;

   // Starts and ends on a falling edge with the DUT idle.
   task automatic run_txn(input bit ren, input bit wen, input logic [2:0] f3,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic [SBW-1:0] sb);
      int nb, off, lat, hold;
      bit legal, misal, mchk, issue;
      longint v;
      logic [DW-1:0] exp_rdata, exp_wdata;
      logic [1:0]    exp_fault;
      logic [3:0]    exp_strb;
      nb    = 1 << f3[1:0];
      off   = int'(addr[1:0]);
      legal = ren ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : wen ? (f3 inside {3'd0, 3'd1, 3'd2}) : 1'b1;
      misal = (int'(addr[2:0]) % nb) != 0;
`ifdef LSU_MISALIGN_CHECK_EN
      mchk = 1'b1;
`else
      mchk = 1'b0;
`endif
      issue = (ren || wen) && legal && !(mchk && misal);
      exp_fault = 2'b00;
      exp_rdata = '0;
      if ((ren || wen) && !issue) exp_fault = 2'b11;
      else if (ren) begin
         if (sl_rresp != 2'b00) exp_fault = 2'b01;
         else begin
            v = (longint'(sl_rdata) >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
            if (!f3[2] && v[8 * nb - 1]) v = v - (64'sd1 << (8 * nb));
            exp_rdata = v[31:0];
         end
      end else if (wen && sl_bresp != 2'b00) exp_fault = 2'b10;
      for (int b = 0; b < 4; b++) exp_strb[b] = (b >= off) && (b < off + nb);
      exp_wdata = wd << (8 * off);

      ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      in_valid = 1; in_mem_ren = ren; in_mem_wen = wen; in_funct3 = f3;
      in_addr = addr; in_wdata = wd; in_sb = sb;
      lat = 0;
      while (!in_ready && lat < 20) begin @(negedge clock); lat++; end
      if (!in_ready) begin check("accept_timeout", in_ready, 1'b1); in_valid = 0; return; end
      @(posedge clock);
      @(negedge clock);
      in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 60) begin @(negedge clock); lat++; end
      if (!out_valid) begin check("out_valid_timeout", out_valid, 1'b1); return; end
      if (!issue) check("latency_nomem", lat, 1);
      else if (sl_fast && sl_w_lag == 0) check("latency_mem", lat, 3);
      check("out_rdata", out_rdata, exp_rdata);
      check("out_fault", out_fault, exp_fault);
      check("out_sb", out_sb, sb);
      check("axi_counts", ar_cnt * 100 + aw_cnt * 10 + w_cnt, (issue && ren) ? 100 : (issue && wen) ? 11 : 0);
      if (issue && ren) begin
         check("araddr", ar_addr, addr);
         check("arsize", ar_size, {1'b0, f3[1:0]});
         check("ar_len_burst_id", ar_misc, {8'd0, 2'b01, 4'(AXI_ID), 4'd0});
      end
      if (issue && wen) begin
         check("awaddr", aw_addr, addr);
         check("awsize", aw_size, {1'b0, f3[1:0]});
         check("aw_len_burst_id", aw_misc, {8'd0, 2'b01, 4'(AXI_ID), 4'd0});
         check("wstrb", w_strb, exp_strb);
         check("wdata", w_data, exp_wdata);
         check("wlast", w_last, 1'b1);
      end
      res_rdata = out_rdata;
      res_fault = out_fault;
      hold = int'($urandom_range(0, 2));
      repeat (hold) @(negedge clock);
      check("hold_stable", {out_valid, out_rdata, out_fault, out_sb}, {1'b1, exp_rdata, exp_fault, sb});
      out_ready = 1;
      @(negedge clock);
      out_ready = 0;
   endtask

   function automatic logic [SBW-1:0] rand_sb();
      return SBW'({$urandom(), $urandom(), $urandom()});
   endfunction

   initial begin
      logic [SBW-1:0] bsb [6];
      int kind;
      repeat (3) @(negedge clock);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out", {out_valid, out_rdata, out_fault, out_sb}, '0);
      check("rst_axi", {arvalid, rready, awvalid, wvalid, bready, busy}, 6'b0);
      reset = 0;
      @(negedge clock);

      sl_fast = 1; sl_rdata = 32'h8011_2233; sl_rresp = 2'b00; sl_bresp = 2'b00;
      run_txn(1, 0, 3'b000, 32'h8000_0003, '0, rand_sb());
      check("lb_rdata", res_rdata, 32'hFFFF_FF80);
      check("lb_arsize", ar_size, 3'b000);

      sl_w_lag = 1;
      run_txn(0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, rand_sb());
      check("sh_wstrb", w_strb, 4'b1100);
      check("sh_wdata", w_data, 32'hABCD_0000);
      check("sh_awsize", aw_size, 3'b001);
      sl_w_lag = 0;

      sl_rresp = 2'b10;
      run_txn(1, 0, 3'b010, 32'h8000_0010, '0, rand_sb());
      check("lw_rresp_fault", {res_fault, res_rdata}, {2'b01, 32'h0});
      sl_rresp = 2'b00; sl_bresp = 2'b11;
      run_txn(0, 1, 3'b010, 32'h8000_0020, 32'hDEAD_BEEF, rand_sb());
      check("sw_bresp_fault", res_fault, 2'b10);
      sl_bresp = 2'b00;

      sl_rdata = 32'hCAFE_F00D;
      run_txn(1, 0, 3'b010, 32'h8000_0102, '0, rand_sb());
`ifdef LSU_MISALIGN_CHECK_EN
      check("lw_misalign_fault", {res_fault, 32'(ar_cnt)}, {2'b11, 32'd0});
`else
      check("lw_misalign_araddr", ar_addr, 32'h8000_0102);
`endif

      out_ready = 1; in_mem_ren = 0; in_mem_wen = 0; in_valid = 1;
      for (int k = 0; k < 6; k++) begin
         bsb[k] = rand_sb();
         in_sb  = bsb[k];
         if (k > 0) begin
            check("b2b_valid_ready", {out_valid, in_ready}, 2'b11);
            check("b2b_sb", out_sb, bsb[k-1]);
         end
         @(negedge clock);
      end
      in_valid = 0;
      check("b2b_last_sb", out_sb, bsb[5]);
      @(negedge clock);
      out_ready = 0;

      sl_stall = 1;
      in_valid = 1; in_mem_wen = 1; in_funct3 = 3'b010; in_addr = 32'h8000_0040; in_wdata = 32'h5555_AAAA;
      @(negedge clock);
      in_valid = 0; in_mem_wen = 0;
      check("wreq_valids", {awvalid, wvalid, busy}, 3'b111);
      reset = 1;
      @(negedge clock);
      check("rst_wreq_valids", {awvalid, wvalid, busy}, 3'b000);
      check("rst_wreq_in_ready", in_ready, 1'b1);
      @(negedge clock);
      reset = 0; sl_stall = 0;
      @(negedge clock);

      for (int t = 0; t < 200; t++) begin
         kind     = int'($urandom_range(0, 2));
         sl_fast  = 1'($urandom_range(0, 1));
         sl_rdata = $urandom();
         sl_rresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         sl_bresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_txn(kind == 0, kind == 1,
                 (kind == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6)),
                 $urandom(), $urandom(), rand_sb());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
